// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: CDB broadcast format, tag matching and
// the per-entry record held in the circular buffer.
package store_queue_pkg;
  localparam int ROB_WIDTH      = 6;
  localparam int DATA_MEM_WIDTH = 16;
  localparam int N_B_ENTRY      = 4;
  localparam int SQ_DATA_W      = 32;
  localparam int SQ_B_W         = $clog2(N_B_ENTRY) + 1;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [SQ_DATA_W-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic                      valid;
    logic                      addr_valid;
    logic [DATA_MEM_WIDTH-1:0] addr;
    logic                      fpr;
    cdb_t                      data;
    logic [SQ_B_W-1:0]         b_count;
  } sq_entry_t;

  function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction
endpackage

// File: rtl/sq_fwd_search.sv
// Store-to-load forwarding search: scans the stores older than a load and
// reports stall / forward / data from the youngest address match.
module sq_fwd_search
  import store_queue_pkg::*;
#(
  parameter int  N_ENTRY = 8,
  localparam int IDX_W   = $clog2(N_ENTRY)
) (
  input  sq_entry_t [N_ENTRY-1:0]       entries,
  input  logic      [IDX_W:0]           head,
  input  logic                          ld_valid,
  input  logic      [DATA_MEM_WIDTH-1:0] ld_addr,
  input  logic      [IDX_W:0]           ld_tail,
  output logic                          stall,
  output logic                          fwd,
  output logic      [SQ_DATA_W-1:0]     data
);
  logic [IDX_W:0]         n_older;
  logic [IDX_W-1:0]       slot;
  logic                   unknown, hit, hit_ready;
  logic [SQ_DATA_W-1:0]   hit_data;
  logic                   unused_bits;

  assign n_older     = ld_tail - head;
  assign unused_bits = ^entries;

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    unknown   = 1'b0;
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    slot      = '0;
    for (int k = 0; k < N_ENTRY; k++) begin
      slot = head[IDX_W-1:0] + IDX_W'(k);
      if (ld_valid && ((IDX_W+1)'(k) < n_older) && entries[slot].valid) begin
        if (!entries[slot].addr_valid) begin
          unknown = 1'b1;
        end else if (entries[slot].addr == ld_addr) begin
          hit       = 1'b1;
          hit_ready = entries[slot].data.valid;
          hit_data  = entries[slot].data.data;
        end
      end
    end
  end

  assign stall = unknown || (hit && !hit_ready);
  assign fwd   = !unknown && hit && hit_ready;
  assign data  = fwd ? hit_data : '0;
endmodule

// File: rtl/store_queue.sv
// In-order circular store queue: holds speculative stores, commits them to
// memory once resolved, and answers store-to-load forwarding queries.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int  N_ENTRY = 8,
  parameter int  ADDR_W  = DATA_MEM_WIDTH,
  parameter int  DATA_W  = 32,
  parameter int  TAG_W   = ROB_WIDTH,
  parameter int  B_W     = $clog2(N_B_ENTRY) + 1,
  localparam int IDX_W   = $clog2(N_ENTRY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_addr_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  cdb_t              alloc_data,
  input  logic              alloc_fpr,
  input  logic [B_W-1:0]    alloc_b_count,
  output logic [IDX_W:0]    alloc_idx,
  input  logic              agu_valid,
  input  logic [IDX_W-1:0]  agu_idx,
  input  logic [ADDR_W-1:0] agu_addr,
  input  cdb_t              gpr_cdb,
  input  cdb_t              fpr_cdb,
  input  logic              b_commit,
  input  logic              failure,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [IDX_W:0]    ld_tail,
  output logic              ld_stall,
  output logic              ld_fwd,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [IDX_W:0]    count,
  output logic              empty
);
  localparam int PW = IDX_W + 1;

  sq_entry_t [N_ENTRY-1:0] q, view;
  sq_entry_t               new_entry;
  cdb_t                    alloc_snoop, alloc_cdb;
  logic [TAG_W-1:0]        alloc_tag;
  logic [PW-1:0]           head, tail, head_next, n_keep;
  logic [IDX_W-1:0]        head_idx, tail_idx;
  logic                    full, commit_fire, alloc_fire;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  // Entries as seen this cycle, with same-cycle CDB results folded in.
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      view[i] = q[i];
      if (q[i].valid && !q[i].data.valid &&
          tag_match(q[i].fpr ? fpr_cdb : gpr_cdb, q[i].data.tag)) begin
        view[i].data.valid = 1'b1;
        view[i].data.data  = q[i].fpr ? fpr_cdb.data : gpr_cdb.data;
      end
    end
  end

  always_comb begin
    n_keep = '0;
    for (int i = 0; i < N_ENTRY; i++)
      if (q[i].valid && q[i].b_count == '0) n_keep = n_keep + PW'(1);
  end

  assign alloc_snoop = alloc_fpr ? fpr_cdb : gpr_cdb;
  assign alloc_tag   = alloc_data.tag;

  always_comb begin
    alloc_cdb = alloc_data;
    if (!alloc_data.valid && tag_match(alloc_snoop, alloc_tag)) begin
      alloc_cdb.valid = 1'b1;
      alloc_cdb.data  = alloc_snoop.data;
    end
    new_entry = '{valid:      1'b1,
                  addr_valid: alloc_addr_valid,
                  addr:       alloc_addr,
                  fpr:        alloc_fpr,
                  data:       alloc_cdb,
                  b_count:    (b_commit && alloc_b_count != '0) ? alloc_b_count - 1'b1
                                                                : alloc_b_count};
  end

  assign mem_we = view[head_idx].valid && view[head_idx].addr_valid &&
                  view[head_idx].data.valid && (view[head_idx].b_count == '0);
  assign mem_addr    = view[head_idx].addr;
  assign mem_data    = view[head_idx].data.data;
  assign commit_fire = mem_we && mem_ready;

  assign count       = tail - head;
  assign empty       = (count == '0);
  assign full        = (count == PW'(N_ENTRY));
  assign alloc_ready = !full || commit_fire;
  assign alloc_fire  = alloc_valid && alloc_ready && !failure;
  assign alloc_idx   = tail;
  assign head_next   = head + PW'(commit_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) begin
        q[i] <= view[i];
        if (b_commit && view[i].b_count != '0)
          q[i].b_count <= view[i].b_count - 1'b1;
        if (agu_valid && agu_idx == IDX_W'(i)) begin
          q[i].addr_valid <= 1'b1;
          q[i].addr       <= agu_addr;
        end
        if (failure && view[i].b_count != '0) q[i] <= '0;
      end
      if (commit_fire) q[head_idx] <= '0;
      if (alloc_fire)  q[tail_idx] <= new_entry;
      head <= head_next;
      // Survivors are contiguous from head; the committing one is already gone.
      if (failure)         tail <= head_next + n_keep - PW'(commit_fire);
      else if (alloc_fire) tail <= tail + PW'(1);
    end
  end

  sq_fwd_search #(.N_ENTRY(N_ENTRY)) u_fwd (
    .entries (view),
    .head    (head),
    .ld_valid(ld_valid),
    .ld_addr (ld_addr),
    .ld_tail (ld_tail),
    .stall   (ld_stall),
    .fwd     (ld_fwd),
    .data    (ld_data)
  );
endmodule

// File: tb/tb_store_queue.sv
// Scenario bench for store_queue: commits are checked against a queue of
// expected (addr, data) pairs; queries and occupancy are checked inline.
module tb_store_queue;
  import store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid, alloc_ready, alloc_addr_valid, alloc_fpr;
  logic [15:0] alloc_addr;
  cdb_t        alloc_data, gpr_cdb, fpr_cdb;
  logic [2:0]  alloc_b_count;
  logic [3:0]  alloc_idx;
  logic        agu_valid;
  logic [2:0]  agu_idx;
  logic [15:0] agu_addr;
  logic        b_commit, failure;
  logic        ld_valid, ld_stall, ld_fwd;
  logic [15:0] ld_addr;
  logic [3:0]  ld_tail;
  logic [31:0] ld_data;
  logic        mem_we, mem_ready, empty;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  count;

  typedef struct { logic [15:0] addr; logic [31:0] data; } exp_t;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] pend_addr = '0;
  int         n_pass = 0;
  int         n_checks = 0;

  store_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_addr_valid(alloc_addr_valid), .alloc_addr(alloc_addr),
    .alloc_data(alloc_data), .alloc_fpr(alloc_fpr), .alloc_b_count(alloc_b_count),
    .alloc_idx(alloc_idx),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr),
    .gpr_cdb(gpr_cdb), .fpr_cdb(fpr_cdb),
    .b_commit(b_commit), .failure(failure),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_tail(ld_tail),
    .ld_stall(ld_stall), .ld_fwd(ld_fwd), .ld_data(ld_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Commit scoreboard: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL commit_unexpected: got addr=%h data=%h, want no commit", mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_data !== mon_e.data)
          $display("FAIL commit_order: got addr=%h data=%h, want addr=%h data=%h",
                   mem_addr, mem_data, mon_e.addr, mon_e.data);
        else n_pass++;
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic alloc_one(input logic av, input logic [15:0] a, input logic dv,
                           input logic [5:0] tg, input logic [31:0] d, input logic f,
                           input logic [2:0] bc, input logic expect_commit,
                           output logic [3:0] idx);
    alloc_valid = 1'b1; alloc_addr_valid = av; alloc_addr = a;
    alloc_data = '{valid: dv, tag: tg, data: d}; alloc_fpr = f; alloc_b_count = bc;
    idx = alloc_idx;
    if (!av) pend_addr[idx[2:0]] = 1'b1;
    if (expect_commit) exp_q.push_back('{addr: a, data: d});
    sync();
    alloc_valid = 1'b0;
  endtask

  task automatic drain();
    sync();
    mem_ready = 1'b1;
    for (int n = 0; n < 64 && empty !== 1'b1; n++) sync();
    n_checks++;
    if (empty !== 1'b1 || exp_q.size() != 0)
      $display("FAIL drain: empty=%b pending_expected=%0d, want empty=1 pending=0", empty, exp_q.size());
    else n_pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 16'h0; ld_tail = 4'd0;
    @(negedge clk);
    n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); else n_pass++;
    n_checks++; if (alloc_idx !== 4'd0) $display("FAIL reset_alloc_idx: got %0d want 0", alloc_idx); else n_pass++;
    n_checks++;
    if ({ld_stall, ld_fwd, ld_data} !== 34'd0)
      $display("FAIL reset_ld: got stall=%b fwd=%b data=%h want 0", ld_stall, ld_fwd, ld_data);
    else n_pass++;
    sync();
    ld_valid = 1'b0;
  endtask

  task automatic test_commit();
    logic [3:0] idx;
    sync();
    mem_ready = 1'b1;
    alloc_one(1'b1, 16'h10, 1'b1, 6'd0, 32'd5, 1'b0, 3'd0, 1'b1, idx);
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h10 || mem_data !== 32'd5)
      $display("FAIL commit_next_cycle: got we=%b addr=%h data=%h want we=1 addr=0010 data=5",
               mem_we, mem_addr, mem_data);
    else n_pass++;
    sync();
    n_checks++; if (empty !== 1'b1) $display("FAIL commit_empty: got %b want 1", empty); else n_pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] idx;
    sync();
    for (int i = 0; i < 8; i++)
      alloc_one(1'b1, 16'h100 + 16'(i), 1'b1, 6'd0, 32'(100 + i), 1'b0, 3'd0, 1'b1, idx);
    @(negedge clk);
    n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_alloc_ready: got %b want 0", alloc_ready); else n_pass++;
    n_checks++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else n_pass++;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h100)
      $display("FAIL full_hold: got we=%b addr=%h want we=1 addr=0100", mem_we, mem_addr);
    else n_pass++;
    sync();
    mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      alloc_valid = 1'b1; alloc_addr_valid = 1'b1; alloc_addr = 16'h200 + 16'(j);
      alloc_data = '{valid: 1'b1, tag: 6'd0, data: 32'(200 + j)};
      alloc_fpr = 1'b0; alloc_b_count = 3'd0;
      exp_q.push_back('{addr: 16'h200 + 16'(j), data: 32'(200 + j)});
      #1;
      n_checks++;
      if (alloc_ready !== 1'b1) $display("FAIL full_commit_ready[%0d]: got %b want 1", j, alloc_ready);
      else n_pass++;
      sync();
      n_checks++;
      if (count !== 4'd8) $display("FAIL full_steady_count[%0d]: got %0d want 8", j, count);
      else n_pass++;
    end
    alloc_valid = 1'b0;
    drain();
  endtask

  task automatic test_fwd();
    logic [3:0] ia, ib;
    sync();
    alloc_one(1'b1, 16'h20, 1'b1, 6'd0, 32'd1, 1'b0, 3'd0, 1'b1, ia);
    alloc_one(1'b1, 16'h20, 1'b1, 6'd0, 32'd2, 1'b0, 3'd0, 1'b1, ib);
    ld_valid = 1'b1; ld_addr = 16'h20; ld_tail = ib + 4'd1;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'd2)
      $display("FAIL fwd_youngest: got fwd=%b stall=%b data=%h want fwd=1 stall=0 data=2", ld_fwd, ld_stall, ld_data);
    else n_pass++;
    ld_tail = ib;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'd1)
      $display("FAIL fwd_between: got fwd=%b data=%h want fwd=1 data=1", ld_fwd, ld_data);
    else n_pass++;
    ld_tail = ia;
    #1;
    n_checks++;
    if ({ld_stall, ld_fwd, ld_data} !== 34'd0)
      $display("FAIL fwd_none_older: got stall=%b fwd=%b data=%h want 0", ld_stall, ld_fwd, ld_data);
    else n_pass++;
    ld_valid = 1'b0; ld_tail = ib + 4'd1;
    #1;
    n_checks++;
    if ({ld_stall, ld_fwd, ld_data} !== 34'd0)
      $display("FAIL fwd_ld_invalid: got stall=%b fwd=%b data=%h want 0", ld_stall, ld_fwd, ld_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_stall();
    logic [3:0] ic;
    sync();
    alloc_one(1'b0, 16'h0, 1'b1, 6'd0, 32'd7, 1'b0, 3'd0, 1'b0, ic);
    exp_q.push_back('{addr: 16'h30, data: 32'd7});
    ld_valid = 1'b1; ld_addr = 16'h30; ld_tail = ic + 4'd1;
    #1;
    n_checks++; if (ld_stall !== 1'b1) $display("FAIL stall_no_addr: got %b want 1", ld_stall); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL commit_no_addr: got we=%b want 0", mem_we); else n_pass++;
    sync();
    assert (pend_addr[ic[2:0]]) else $error("agu fill of an entry without a pending address");
    agu_valid = 1'b1; agu_idx = ic[2:0]; agu_addr = 16'h30;
    pend_addr[ic[2:0]] = 1'b0;
    sync();
    agu_valid = 1'b0; ld_addr = 16'h40;
    #1;
    n_checks++;
    if (ld_stall !== 1'b0 || ld_fwd !== 1'b0)
      $display("FAIL stall_miss: got stall=%b fwd=%b want 0 0", ld_stall, ld_fwd);
    else n_pass++;
    ld_addr = 16'h30;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'd7 || mem_we !== 1'b1)
      $display("FAIL stall_after_agu: got fwd=%b data=%h we=%b want 1 7 1", ld_fwd, ld_data, mem_we);
    else n_pass++;
    ld_valid = 1'b0;
    drain();
  endtask

  task automatic test_cdb_snoop();
    logic [3:0] i0, i1;
    sync();
    gpr_cdb = '{valid: 1'b1, tag: 6'd3, data: 32'hABCD};
    alloc_one(1'b1, 16'h50, 1'b0, 6'd3, 32'hDEAD, 1'b0, 3'd0, 1'b0, i0);
    gpr_cdb = '0;
    exp_q.push_back('{addr: 16'h50, data: 32'hABCD});
    alloc_one(1'b1, 16'h60, 1'b0, 6'd9, 32'hBEEF, 1'b1, 3'd0, 1'b0, i1);
    exp_q.push_back('{addr: 16'h60, data: 32'h1234});
    ld_valid = 1'b1; ld_addr = 16'h50; ld_tail = i0 + 4'd1;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'hABCD)
      $display("FAIL snoop_alloc: got fwd=%b data=%h want fwd=1 data=abcd", ld_fwd, ld_data);
    else n_pass++;
    ld_addr = 16'h60; ld_tail = i1 + 4'd1;
    gpr_cdb = '{valid: 1'b1, tag: 6'd9, data: 32'h5555};
    #1;
    n_checks++; if (ld_stall !== 1'b1) $display("FAIL snoop_wrong_bus: got stall=%b want 1", ld_stall); else n_pass++;
    gpr_cdb = '0;
    fpr_cdb = '{valid: 1'b1, tag: 6'd9, data: 32'h1234};
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'h1234)
      $display("FAIL snoop_bypass: got fwd=%b data=%h want fwd=1 data=1234", ld_fwd, ld_data);
    else n_pass++;
    sync();
    fpr_cdb = '0;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'h1234)
      $display("FAIL snoop_captured: got fwd=%b data=%h want fwd=1 data=1234", ld_fwd, ld_data);
    else n_pass++;
    ld_valid = 1'b0;
    drain();
  endtask

  task automatic test_failure();
    logic [3:0] h, idx;
    sync();
    h = alloc_idx;
    alloc_one(1'b1, 16'h70, 1'b1, 6'd0, 32'h77, 1'b0, 3'd0, 1'b1, idx);
    alloc_one(1'b1, 16'h71, 1'b1, 6'd0, 32'h11, 1'b0, 3'd1, 1'b0, idx);
    alloc_one(1'b1, 16'h72, 1'b1, 6'd0, 32'h22, 1'b0, 3'd1, 1'b0, idx);
    failure = 1'b1;
    alloc_valid = 1'b1; alloc_addr_valid = 1'b1; alloc_addr = 16'h73;
    alloc_data = '{valid: 1'b1, tag: 6'd0, data: 32'h33}; alloc_b_count = 3'd0;
    sync();
    failure = 1'b0; alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd1) $display("FAIL flush_count: got %0d want 1", count); else n_pass++;
    n_checks++; if (alloc_idx !== h + 4'd1) $display("FAIL flush_tail: got %0d want %0d", alloc_idx, h + 4'd1); else n_pass++;
    b_commit = 1'b1;
    sync();
    b_commit = 1'b0;
    n_checks++;
    if (count !== 4'd1 || mem_we !== 1'b1 || mem_addr !== 16'h70 || mem_data !== 32'h77)
      $display("FAIL bcommit_no_change: got count=%0d we=%b addr=%h data=%h want 1 1 0070 77",
               count, mem_we, mem_addr, mem_data);
    else n_pass++;
    b_commit = 1'b1;
    alloc_one(1'b1, 16'h74, 1'b1, 6'd0, 32'h44, 1'b0, 3'd1, 1'b1, idx);
    b_commit = 1'b0;
    failure = 1'b1;
    sync();
    failure = 1'b0;
    n_checks++; if (count !== 4'd2) $display("FAIL alloc_bcommit_survive: got %0d want 2", count); else n_pass++;
    drain();
  endtask

  initial begin
    alloc_valid = 1'b0; alloc_addr_valid = 1'b0; alloc_addr = '0; alloc_data = '0;
    alloc_fpr = 1'b0; alloc_b_count = '0; agu_valid = 1'b0; agu_idx = '0; agu_addr = '0;
    gpr_cdb = '0; fpr_cdb = '0; b_commit = 1'b0; failure = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_tail = '0; mem_ready = 1'b0;
    test_reset();
    test_commit();
    test_back_to_back();
    test_fwd();
    test_stall();
    test_cdb_snoop();
    test_failure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
